// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged
//   Single-clock FIFO with an occupancy count, almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags and a selectable read mode
//   (registered 1-cycle latency, or first-word-fall-through).
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   w_en         write request; accepted when not full
//   data_in      write data
//   r_en         read request (FWFT=0) / head-word acknowledge (FWFT=1)
//   clr_err      synchronous clear of overflow and underflow
//   data_out     read data
//   full         FIFO holds DEPTH words
//   empty        FIFO holds no words
//   almost_full  count >= AFULL_THRESH
//   almost_empty count <= AEMPTY_THRESH
//   count        occupancy, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module sync_fifo_flagged #(
    parameter int DEPTH         = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int PTR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    // Thresholds sized to the count width so the compares are width-exact.
    localparam logic [PTR_WIDTH:0] AF_LIM = AFULL_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AE_LIM = AEMPTY_THRESH[PTR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wptr;
    logic [PTR_WIDTH:0]    rptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the registered pointers; the extra MSB on each
    // pointer distinguishes full from empty when the address bits match.
    always_comb begin
        empty        = (wptr == rptr);
        full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                       (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
        count        = wptr - rptr;
        almost_full  = (count >= AF_LIM);
        almost_empty = (count <= AE_LIM);
        // No write-through on full and no bypass on empty: each side is gated
        // only by its own flag.
        wr_acc       = w_en && !full;
        rd_acc       = r_en && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr[PTR_WIDTH-1:0]] <= data_in;
    end

    // A set condition on the same edge as clr_err keeps the flag high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full)  overflow <= 1'b1;
            else if (clr_err)  overflow <= 1'b0;
            if (r_en && empty) underflow <= 1'b1;
            else if (clr_err)  underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero while empty.
            always_comb begin
                data_out = '0;
                if (!empty) data_out = mem[rptr[PTR_WIDTH-1:0]];
            end
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      data_q <= '0;
                else if (rd_acc) data_q <= mem[rptr[PTR_WIDTH-1:0]];
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule
